// File: rtl/epcs_read_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : epcs_read_sequencer_if
// Purpose  : Bundles the SPI register-map master port and the read-byte
//            valid/ready stream of the EPCS read sequencer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface epcs_read_sequencer_if;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_read_n;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;

  // Sequencer side: drives the SPI bus and sources the byte stream.
  modport master (
    output m_address, m_chipselect, m_read_n, m_write_n, m_writedata,
    input  m_readdata,
    output rd_data, rd_valid,
    input  rd_ready
  );

  // Peripheral/consumer side.
  modport slave (
    input  m_address, m_chipselect, m_read_n, m_write_n, m_writedata,
    output m_readdata,
    input  rd_data, rd_valid,
    output rd_ready
  );
endinterface
`default_nettype wire

// File: rtl/epcs_read_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : epcs_read_sequencer
// Purpose  : Drives an SPI master register map to issue an EPCS READ (0x03)
//            command and streams the returned flash bytes out on a
//            valid/ready interface, one byte in flight at a time.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module epcs_read_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [23:0]      flash_addr,
  input  logic [LEN_W-1:0] byte_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  epcs_read_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, SEL, SSO_ON, TX_POLL, TX_WR, RX_POLL, RX_RD, OUT, TMT_POLL, SSO_OFF, FIN
  } state_t;

  // Every bus access is phase 0/1 active and phase 2 idle.
  localparam logic [1:0] C_PH_LAST = 2'd2;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       hdr_idx_q, hdr_idx_d;
  logic             in_hdr_q, in_hdr_d;
  logic             err_q, err_d;
  logic             zdone_q, zdone_d;
  logic [3:0]       stat_q, stat_d;     // {E, RRDY, TRDY, TMT} from last read
  logic [7:0]       rd_data_q, rd_data_d;

  logic             w_acc_rd, w_acc_wr, w_last;
  logic [2:0]       w_acc_a;
  logic [15:0]      w_acc_d;
  logic [7:0]       w_tx_byte;
  logic             w_unused_rdata;

  assign w_unused_rdata = ^bus.m_readdata[15:9];
  assign w_last         = (phase_q == C_PH_LAST);

  // Byte to transmit: READ command + 3 address bytes, then dummy zeros.
  always_comb begin
    w_tx_byte = 8'h00;
    if (in_hdr_q) begin
      case (hdr_idx_q)
        2'd0:    w_tx_byte = 8'h03;
        2'd1:    w_tx_byte = addr_q[23:16];
        2'd2:    w_tx_byte = addr_q[15:8];
        default: w_tx_byte = addr_q[7:0];
      endcase
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= 2'd0;
      addr_q    <= 24'd0;
      rem_q     <= '0;
      hdr_idx_q <= 2'd0;
      in_hdr_q  <= 1'b0;
      err_q     <= 1'b0;
      zdone_q   <= 1'b0;
      stat_q    <= 4'd0;
      rd_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      hdr_idx_q <= hdr_idx_d;
      in_hdr_q  <= in_hdr_d;
      err_q     <= err_d;
      zdone_q   <= zdone_d;
      stat_q    <= stat_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next-state logic, bus access sequencing and outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    hdr_idx_d = hdr_idx_q;
    in_hdr_d  = in_hdr_q;
    err_d     = err_q;
    zdone_d   = 1'b0;
    stat_d    = stat_q;
    rd_data_d = rd_data_q;
    w_acc_rd  = 1'b0;
    w_acc_wr  = 1'b0;
    w_acc_a   = 3'd0;
    w_acc_d   = 16'h0000;
    bus.rd_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (byte_count != '0) begin
            addr_d    = flash_addr;
            rem_d     = byte_count;
            hdr_idx_d = 2'd0;
            in_hdr_d  = 1'b1;
            state_d   = SEL;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      SEL: begin
        w_acc_wr = 1'b1; w_acc_a = 3'd5; w_acc_d = 16'h0001;
        if (w_last) state_d = SSO_ON;
      end
      SSO_ON: begin
        w_acc_wr = 1'b1; w_acc_a = 3'd3; w_acc_d = 16'h0400;
        if (w_last) state_d = TX_POLL;
      end
      TX_POLL: begin
        w_acc_rd = 1'b1; w_acc_a = 3'd2;
        if (w_last) begin
          if (stat_q[3]) begin
            err_d   = 1'b1;
            state_d = SSO_OFF;
          end else if (stat_q[1]) begin
            state_d = TX_WR;
          end
        end
      end
      TX_WR: begin
        w_acc_wr = 1'b1; w_acc_a = 3'd1; w_acc_d = {8'h00, w_tx_byte};
        if (w_last) state_d = RX_POLL;
      end
      RX_POLL: begin
        w_acc_rd = 1'b1; w_acc_a = 3'd2;
        if (w_last) begin
          if (stat_q[3]) begin
            err_d   = 1'b1;
            state_d = SSO_OFF;
          end else if (stat_q[2]) begin
            state_d = RX_RD;
          end
        end
      end
      RX_RD: begin
        w_acc_rd = 1'b1; w_acc_a = 3'd0;
        if (phase_q == 2'd1) rd_data_d = bus.m_readdata[7:0];
        if (w_last) begin
          if (in_hdr_q) begin
            // Header echo bytes are dropped; the 4th one opens the data phase.
            if (hdr_idx_q == 2'd3) in_hdr_d = 1'b0;
            else hdr_idx_d = hdr_idx_q + 2'd1;
            state_d = TX_POLL;
          end else begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        bus.rd_valid = 1'b1;
        if (bus.rd_ready) begin
          if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
          state_d = (rem_q <= LEN_W'(1)) ? TMT_POLL : TX_POLL;
        end
      end
      TMT_POLL: begin
        w_acc_rd = 1'b1; w_acc_a = 3'd2;
        if (w_last) begin
          if (stat_q[3]) begin
            err_d   = 1'b1;
            state_d = SSO_OFF;
          end else if (stat_q[0]) begin
            state_d = SSO_OFF;
          end
        end
      end
      SSO_OFF: begin
        w_acc_wr = 1'b1; w_acc_a = 3'd3; w_acc_d = 16'h0000;
        if (w_last) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Two active cycles then one idle; readdata captured on the 2nd cycle.
    bus.m_chipselect = 1'b0;
    bus.m_read_n     = 1'b1;
    bus.m_write_n    = 1'b1;
    bus.m_address    = 3'd0;
    bus.m_writedata  = 16'h0000;
    if ((w_acc_rd || w_acc_wr) && !w_last) begin
      bus.m_chipselect = 1'b1;
      bus.m_read_n     = ~w_acc_rd;
      bus.m_write_n    = ~w_acc_wr;
      bus.m_address    = w_acc_a;
      bus.m_writedata  = w_acc_d;
    end
    if (w_acc_rd && phase_q == 2'd1) stat_d = bus.m_readdata[8:5];
    if (w_acc_rd || w_acc_wr) phase_d = w_last ? 2'd0 : phase_q + 2'd1;
    else phase_d = 2'd0;

    bus.rd_data = rd_data_q;
    busy  = (state_q != IDLE) && (state_q != FIN);
    done  = (state_q == FIN) || zdone_q;
    error = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_epcs_read_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_epcs_read_sequencer
// Purpose  : Self-checking bench for epcs_read_sequencer with an SPI
//            register-map model and a byte-stream scoreboard.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_epcs_read_sequencer;

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [23:0] addr;
    int          count;
    int          ready_pct;   // 0 = hold rd_ready low 20 cycles first
    int          e_poll;      // status poll index reporting E (0 = never)
    bit          poke;        // re-assert start while busy
    bit          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] flash_addr;
  logic [15:0] byte_count;
  logic        busy, done, error;
  logic        rd_ready;
  logic [15:0] model_rdata;

  int n_vec = 0;
  int n_fail = 0;

  epcs_read_sequencer_if bus_if ();
  assign bus_if.m_readdata = model_rdata;
  assign bus_if.rd_ready   = rd_ready;

  epcs_read_sequencer #(.LEN_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .flash_addr (flash_addr),
    .byte_count (byte_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bus        (bus_if.master)
  );

  always #5 clk = ~clk;

  // ---------------- SPI register-map model ----------------
  wr_t        wlog[$];
  logic [7:0] dq[$];
  int  tx_count = 0, tx_base = 0, status_reads = 0, sr_base = 0;
  int  e_poll = 0, tx_at_e = 0, n_access = 0, proto_bad = 0;
  int  shift_cnt, acc_cyc;
  bit  prev_cs, rx_full, e_now;
  logic [7:0] rx_byte;

  always_comb begin
    e_now = (e_poll != 0) && ((status_reads - sr_base) == e_poll);
    model_rdata = 16'h0000;
    if (bus_if.m_address == 3'd0) model_rdata = {8'h00, rx_byte};
    else if (bus_if.m_address == 3'd2)
      model_rdata = {7'd0, e_now, rx_full, shift_cnt == 0, shift_cnt == 0, 5'd0};
  end

  always @(posedge clk or negedge reset_n) begin
    int k;
    if (!reset_n) begin
      prev_cs <= 1'b0; acc_cyc <= 0; shift_cnt <= 0; rx_full <= 1'b0; rx_byte <= 8'h00;
    end else begin
      prev_cs <= bus_if.m_chipselect;
      if (bus_if.m_chipselect) acc_cyc <= acc_cyc + 1;
      else if (prev_cs) begin
        if (acc_cyc != 2) proto_bad++;
        acc_cyc <= 0;
      end
      if (bus_if.m_chipselect && !prev_cs) begin
        n_access <= n_access + 1;
        if (bus_if.m_read_n == bus_if.m_write_n) proto_bad++;
        if (!bus_if.m_write_n) begin
          wlog.push_back('{bus_if.m_address, bus_if.m_writedata});
          if (bus_if.m_address == 3'd1) begin
            k = tx_count - tx_base;
            if (k < 4) rx_byte <= 8'hC0 + 8'(k);
            else if (k - 4 < dq.size()) rx_byte <= dq[k-4];
            else rx_byte <= 8'hEE;
            tx_count  <= tx_count + 1;
            shift_cnt <= $urandom_range(4, 1);
          end
        end
        if (!bus_if.m_read_n && bus_if.m_address == 3'd2) status_reads <= status_reads + 1;
      end
      if (bus_if.m_chipselect && prev_cs && !bus_if.m_read_n) begin
        if (bus_if.m_address == 3'd0) rx_full <= 1'b0;
        if (bus_if.m_address == 3'd2 && e_now) tx_at_e <= tx_count;
      end
      if (shift_cnt > 0) begin
        shift_cnt <= shift_cnt - 1;
        if (shift_cnt == 1) rx_full <= 1'b1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_rdv"},   32'(bus_if.rd_valid), 0);
    chk({tag, "_rdd"},   32'(bus_if.rd_data), 0);
    chk({tag, "_cs"},    32'(bus_if.m_chipselect), 0);
    chk({tag, "_rdn"},   32'(bus_if.m_read_n), 1);
    chk({tag, "_wrn"},   32'(bus_if.m_write_n), 1);
    chk({tag, "_addr"},  32'(bus_if.m_address), 0);
    chk({tag, "_wdata"}, 32'(bus_if.m_writedata), 0);
  endtask

  // Expected register writes derived directly from the read protocol.
  function automatic void build_writes(input logic [23:0] a, input int n, output wr_t q[$]);
    q = {};
    q.push_back('{3'd5, 16'h0001});
    q.push_back('{3'd3, 16'h0400});
    q.push_back('{3'd1, 16'h0003});
    q.push_back('{3'd1, {8'h00, a[23:16]}});
    q.push_back('{3'd1, {8'h00, a[15:8]}});
    q.push_back('{3'd1, {8'h00, a[7:0]}});
    for (int i = 0; i < n; i++) q.push_back('{3'd1, 16'h0000});
    q.push_back('{3'd3, 16'h0000});
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int wb0, na0, ndone, hold_left, tx_ref, pct, bad;
    bit stab_bad, busy_bad, hold_bad, timeout, prev_v, prev_r;
    logic [7:0] prev_d;
    logic [7:0] got[$];
    wr_t exp_w[$];
    wb0 = wlog.size(); na0 = n_access;
    tx_base = tx_count; sr_base = status_reads; e_poll = v.e_poll;
    stab_bad = 0; busy_bad = 0; hold_bad = 0; timeout = 1; prev_v = 0; prev_r = 0;
    prev_d = 8'h00; ndone = 0; tx_ref = 0;
    pct = (v.ready_pct == 0) ? 100 : v.ready_pct;
    hold_left = (v.ready_pct == 0) ? 20 : 0;
    @(negedge clk);
    start = 1'b1; flash_addr = v.addr; byte_count = 16'(v.count); rd_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; flash_addr = 24'($urandom); byte_count = 16'($urandom);
    if (v.count == 0) begin
      chk({tag, "_zero_done"}, 32'(done), 1);
      chk({tag, "_zero_busy"}, 32'(busy), 0);
      @(negedge clk);
      chk({tag, "_zero_done_once"}, 32'(done), 0);
      repeat (4) @(negedge clk);
      chk({tag, "_zero_no_bus"}, 32'(n_access - na0), 0);
      return;
    end
    chk({tag, "_busy_rise"}, 32'(busy), 1);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (start) start = 1'b0;
      if (v.poke && cyc == 8) begin
        start = 1'b1; flash_addr = 24'h777777; byte_count = 16'd7;
      end
      if (prev_v && !prev_r && (!bus_if.rd_valid || bus_if.rd_data != prev_d)) stab_bad = 1;
      if (done) begin
        ndone++;
        chk({tag, "_busy_at_done"}, 32'(busy), 0);
        chk({tag, "_error"}, 32'(error), 32'(v.exp_err));
        timeout = 0;
        break;
      end
      if (!busy) busy_bad = 1;
      if (bus_if.rd_valid) begin
        if (hold_left > 0) begin
          if (hold_left == 20) tx_ref = tx_count;
          rd_ready = 1'b0;
          hold_left--;
          if (hold_left == 0 && tx_count != tx_ref) hold_bad = 1;
        end else begin
          rd_ready = ($urandom_range(99, 0) < pct);
        end
      end else begin
        rd_ready = 1'($urandom_range(1, 0));
      end
      if (bus_if.rd_valid && rd_ready) got.push_back(bus_if.rd_data);
      prev_v = bus_if.rd_valid; prev_r = rd_ready; prev_d = bus_if.rd_data;
      @(negedge clk);
    end
    start = 1'b0;
    rd_ready = 1'b0;
    chk({tag, "_done_timeout"}, 32'(timeout), 0);
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk({tag, "_done_count"}, 32'(ndone), 1);
    chk({tag, "_rd_stable"}, 32'(stab_bad), 0);
    chk({tag, "_busy_held"}, 32'(busy_bad), 0);
    chk({tag, "_hold_no_tx"}, 32'(hold_bad), 0);
    if (!v.exp_err) begin
      chk({tag, "_nbytes"}, 32'(got.size()), 32'(dq.size()));
      bad = 0;
      for (int i = 0; i < got.size() && i < dq.size(); i++) if (got[i] !== dq[i]) bad++;
      chk({tag, "_rd_bytes"}, 32'(bad), 0);
      build_writes(v.addr, v.count, exp_w);
      chk({tag, "_nwrites"}, 32'(wlog.size() - wb0), 32'(exp_w.size()));
      bad = 0;
      for (int i = 0; i < exp_w.size() && wb0 + i < wlog.size(); i++)
        if (wlog[wb0+i].a !== exp_w[i].a || wlog[wb0+i].d !== exp_w[i].d) bad++;
      chk({tag, "_writes"}, 32'(bad), 0);
    end else begin
      chk({tag, "_err_nbytes"}, 32'(got.size()), 0);
      chk({tag, "_err_tx_after_e"}, 32'(tx_count - tx_at_e), 0);
      chk({tag, "_err_sso_off"}, {13'd0, wlog[$].a, wlog[$].d}, {13'd0, 3'd3, 16'h0000});
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[7];

  initial begin
    vec_t rv;
    bit seen;
    vecs[0] = '{24'h012345, 2, 100, 0, 0, 0};
    vecs[1] = '{24'h012345, 2,   0, 0, 0, 0};
    vecs[2] = '{24'h000000, 0, 100, 0, 0, 0};
    vecs[3] = '{24'hFFFFFF, 1,  50, 0, 0, 0};
    vecs[4] = '{24'h123456, 3, 100, 3, 0, 1};
    vecs[5] = '{24'hABCDEF, 5,  30, 0, 1, 0};
    vecs[6] = '{24'h800001, 3,  70, 1, 0, 1};

    reset_n = 1'b0; start = 1'b0; rd_ready = 1'b0;
    flash_addr = 24'd0; byte_count = 16'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      dq = {};
      if (i == 0 || i == 1) dq = '{8'hA5, 8'h5A};
      else if (!vecs[i].exp_err)
        for (int j = 0; j < vecs[i].count; j++) dq.push_back(8'($urandom));
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    for (int r = 0; r < 6; r++) begin
      rv = '{24'($urandom), int'($urandom_range(8, 1)), int'($urandom_range(100, 20)), 0, 0, 0};
      dq = {};
      for (int j = 0; j < rv.count; j++) dq.push_back(8'($urandom));
      run_vec(rv, $sformatf("rand%0d", r));
    end

    // Reset in the data phase, then a clean transaction.
    dq = '{8'h11, 8'h22, 8'h33, 8'h44};
    tx_base = tx_count; sr_base = status_reads; e_poll = 0;
    @(negedge clk);
    start = 1'b1; flash_addr = 24'h00F00D; byte_count = 16'd4; rd_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 2000; c++) begin
      if (bus_if.rd_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("midreset_reach_data", 32'(seen), 1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("midreset_quiet", 32'(seen), 0);
    dq = '{8'hA5, 8'h5A};
    run_vec(vecs[0], "after_reset");

    chk("bus_protocol", 32'(proto_bad), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/epcs_read_sequencer.md
EPCS_READ_SEQUENCER -- requirements
Module: epcs_read_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 16, giving the width of the byte_count port.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to begin a flash read.
REQ-005 SHALL have port flash_addr, input, 24 bits: flash start byte address, sampled on start.
REQ-006 SHALL have port byte_count, input, LEN_W bits: number of bytes to read, sampled on start.
REQ-007 SHALL have port busy, output, 1 bit: high from the accepted start until done.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a transaction.
REQ-009 SHALL have port error, output, 1 bit: valid with done; set when SPI status bit 8 (E) was seen.
REQ-010 SHALL have ports rd_data (output, 8 bits), rd_valid (output, 1 bit) and rd_ready (input, 1 bit): the flash byte stream, using a valid/ready handshake.
REQ-011 SHALL have ports m_address (output, 3 bits), m_chipselect (output, 1 bit), m_read_n (output, 1 bit), m_write_n (output, 1 bit), m_writedata (output, 16 bits) and m_readdata (input, 16 bits): the master port to the SPI register map.
REQ-012 The SPI register map SHALL be: 0 rxdata, 1 txdata, 2 status, 3 control, 5 slave-select; status bit 5 = TMT, bit 6 = TRDY, bit 7 = RRDY, bit 8 = E; control bit 10 = SSO.

Function
REQ-013 Each bus access SHALL hold m_chipselect and exactly one of m_read_n/m_write_n low for exactly 2 cycles, followed by at least 1 idle cycle.
REQ-014 A read SHALL sample m_readdata on the 2nd cycle of the access.
REQ-015 The FSM states SHALL be: IDLE, SEL, SSO_ON, TX_POLL, TX_WR, RX_POLL, RX_RD, OUT, TMT_POLL, SSO_OFF, FIN.
REQ-016 IDLE -> SEL on start when byte_count != 0; latch the address and count; busy goes high the next cycle.
REQ-017 start with byte_count == 0 SHALL produce a done pulse the next cycle, with no bus access and busy staying low.
REQ-018 start while busy SHALL be ignored.
REQ-019 SEL SHALL write 0x0001 to address 5; SSO_ON SHALL then write 0x0400 to address 3.
REQ-020 The transmit byte sequence SHALL be 0x03, A[23:16], A[15:8], A[7:0] (header, 2-bit index), then byte_count dummy 0x00 bytes.
REQ-021 TX_POLL SHALL read status until TRDY = 1; TX_WR SHALL write the byte to address 1.
REQ-022 RX_POLL SHALL read status until RRDY = 1; RX_RD SHALL read address 0.
REQ-023 Header rx bytes SHALL be discarded; after the 4th header byte, the FSM SHALL move to the data phase.
REQ-024 Data-phase rx bytes SHALL go to OUT: rd_data = m_readdata[7:0], rd_valid = 1, held stable until rd_ready; the transfer completes in the cycle where rd_valid & rd_ready.
REQ-025 After the transfer in OUT, the remaining count SHALL decrement; if it is nonzero, the FSM SHALL go to TX_POLL, else to TMT_POLL.
REQ-026 TMT_POLL SHALL read status until TMT = 1; SSO_OFF SHALL write 0x0000 to address 3; FIN SHALL pulse done for 1 cycle with busy low in the same cycle and return to IDLE.
REQ-027 Any status read with E = 1 SHALL set error and jump to SSO_OFF; error is cleared on the next accepted start.
REQ-028 At most one byte SHALL be in flight: no new txdata write until the prior rx byte has been read.
REQ-029 The maximum transfer SHALL be 2^LEN_W - 1 bytes; the remaining counter SHALL never wrap.

Reset
REQ-030 On reset_n low (asynchronous): state = IDLE; busy, done, error, rd_valid = 0; rd_data = 0; m_chipselect = 0; m_read_n = m_write_n = 1; m_address = 0; m_writedata = 0.
REQ-031 Reset mid-operation SHALL abandon the transfer without a done pulse; the SPI block shares reset_n, so SSO is released by its own reset.

Verification
REQ-032 start, addr 0x012345, count 2, SPI model returns 0xA5, 0x5A -> writes 5:0x0001, 3:0x0400, 1:0x03, 0x01, 0x23, 0x45, 0x00, 0x00, 3:0x0000; rd_data 0xA5 then 0x5A; one done with error = 0.
REQ-033 rd_ready held low 20 cycles during the first data byte -> rd_valid and rd_data stay stable; no further txdata write until the handshake.
REQ-034 start with count 0 -> done the cycle after, no bus activity.
REQ-035 Status E = 1 on the 3rd poll -> error = 1 with done, SSO_OFF write seen, no further txdata writes.
REQ-036 reset_n low in the data phase -> all outputs at reset values immediately; next start runs normally.
REQ-037 start asserted while busy -> ignored; exactly one transaction and one done.
